// File: rtl/tlp_retry_buf_if.sv
// Handshake bundle for tlp_retry_buf: packer-side words in, link-side words out,
// link ack/nack feedback and status flags.
interface tlp_retry_buf_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic        ack;
    logic        nack;
    logic [3:0]  outstanding;
    logic        replay;
    logic        proto_err;
    logic        link_down;

    modport slave (
        input  in_data, in_valid, in_last, out_ready, ack, nack,
        output in_ready, out_data, out_valid, out_last, outstanding, replay, proto_err, link_down
    );

    modport master (
        output in_data, in_valid, in_last, out_ready, ack, nack,
        input  in_ready, out_data, out_valid, out_last, outstanding, replay, proto_err, link_down
    );
endinterface

// File: rtl/tlp_retry_buf.sv
// Store-and-forward TLP retry buffer: holds sent TLPs until acked, replays from the oldest on nack.
// Optional macro TLP_RETRY_LIMIT_EN: the 4th consecutive nack latches link_down until reset.
module tlp_retry_buf #(
    parameter int DEPTH_LOG2 = 6,
    parameter int MAX_TLP    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    tlp_retry_buf_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int FW    = (MAX_TLP > 1) ? $clog2(MAX_TLP) : 1;
    localparam int CW    = $clog2(MAX_TLP + 1);

    typedef enum logic [1:0] {IDLE, XMIT, DRAIN} state_e;

    logic [32:0]   mem [DEPTH];
    logic [PW-1:0] len_q [MAX_TLP];
    logic [PW-1:0] wr_ptr_q, cmt_ptr_q, snd_ptr_q, ack_ptr_q;
    logic [PW-1:0] wr_ptr_d, cmt_ptr_d, snd_ptr_d, ack_ptr_d;
    logic [PW-1:0] in_len_q, in_len_d;
    logic [FW-1:0] head_q, tail_q;
    logic [CW-1:0] tlp_cnt_q, tlp_cnt_d;
    logic [CW-1:0] sent_cnt_q, sent_cnt_d;
    logic [CW-1:0] snd_idx_q, snd_idx_d;
    logic          in_mid_q, in_mid_d, snd_mid_q, snd_mid_d;
    logic          replay_q, perr_q;
    state_e        state_q;

    logic          link_down, in_ready, out_valid, rd_last;
    logic          in_hs, commit, out_hs, last_hs;
    logic          ack_eff, nack_eff, rewind, drain_go, perr_set;
    logic [CW-1:0] sent_after_ack;
    logic [32:0]   rd_word;

    function automatic logic [FW-1:0] nxt(input logic [FW-1:0] p);
        return (p == FW'(MAX_TLP - 1)) ? '0 : p + FW'(1);
    endfunction

    // in_ready only looks at registered pointers, so words freed by an ack are usable next cycle
    assign in_ready  = !rst_n && ((wr_ptr_q - ack_ptr_q) != PW'(DEPTH))
                       && (in_mid_q || (tlp_cnt_q < CW'(MAX_TLP))) && !link_down;
    assign out_valid = (snd_ptr_q != cmt_ptr_q) && !link_down;
    assign rd_word   = mem[snd_ptr_q[PW-2:0]];
    assign rd_last   = rd_word[32];

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_valid ? rd_word[31:0] : 32'h0;
    assign bus.out_last    = out_valid && rd_last;
    assign bus.outstanding = 4'(tlp_cnt_q) + 4'(in_mid_q);
    assign bus.replay      = replay_q;
    assign bus.proto_err   = perr_q;
    assign bus.link_down   = link_down;

    // sent_cnt counts TLPs whose out_last went out at least once; snd_idx is the
    // position of the TLP being sent relative to the oldest held one
    always_comb begin
        in_hs          = bus.in_valid && in_ready;
        commit         = in_hs && bus.in_last;
        out_hs         = out_valid && bus.out_ready;
        last_hs        = out_hs && rd_last;
        ack_eff        = bus.ack && (sent_cnt_q != '0);
        sent_after_ack = sent_cnt_q - CW'(ack_eff);
        nack_eff       = bus.nack && (sent_after_ack != '0) && (state_q != DRAIN);
        perr_set       = (sent_cnt_q == '0) && (bus.ack || bus.nack);
        rewind         = (nack_eff && (!snd_mid_q || last_hs)) || ((state_q == DRAIN) && last_hs);
        drain_go       = nack_eff && snd_mid_q && !last_hs;

        wr_ptr_d   = wr_ptr_q + PW'(in_hs);
        cmt_ptr_d  = commit ? wr_ptr_d : cmt_ptr_q;
        in_len_d   = commit ? '0 : in_len_q + PW'(in_hs);
        in_mid_d   = in_hs ? !bus.in_last : in_mid_q;
        ack_ptr_d  = ack_ptr_q + (ack_eff ? len_q[head_q] : '0);
        tlp_cnt_d  = tlp_cnt_q + CW'(commit) - CW'(ack_eff);
        sent_cnt_d = sent_after_ack + CW'(last_hs && (snd_idx_q == sent_cnt_q));
        snd_idx_d  = snd_idx_q - CW'(ack_eff && (snd_idx_q != '0)) + CW'(last_hs);
        snd_ptr_d  = snd_ptr_q + PW'(out_hs);
        snd_mid_d  = out_hs ? !rd_last : snd_mid_q;
        if (rewind) begin
            snd_ptr_d = ack_ptr_d;
            snd_idx_d = '0;
            snd_mid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q   <= '0;
            cmt_ptr_q  <= '0;
            snd_ptr_q  <= '0;
            ack_ptr_q  <= '0;
            in_len_q   <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            tlp_cnt_q  <= '0;
            sent_cnt_q <= '0;
            snd_idx_q  <= '0;
            in_mid_q   <= 1'b0;
            snd_mid_q  <= 1'b0;
            replay_q   <= 1'b0;
            perr_q     <= 1'b0;
            state_q    <= IDLE;
            for (int i = 0; i < MAX_TLP; i++) len_q[i] <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            cmt_ptr_q  <= cmt_ptr_d;
            snd_ptr_q  <= snd_ptr_d;
            ack_ptr_q  <= ack_ptr_d;
            in_len_q   <= in_len_d;
            tlp_cnt_q  <= tlp_cnt_d;
            sent_cnt_q <= sent_cnt_d;
            snd_idx_q  <= snd_idx_d;
            in_mid_q   <= in_mid_d;
            snd_mid_q  <= snd_mid_d;
            replay_q   <= rewind;
            if (perr_set) perr_q <= 1'b1;
            if (commit) begin
                len_q[tail_q] <= in_len_q + PW'(1);
                tail_q        <= nxt(tail_q);
            end
            if (ack_eff) head_q <= nxt(head_q);
            if (drain_go) state_q <= DRAIN;
            else begin
                case (state_q)
                    IDLE:    if (snd_ptr_q != cmt_ptr_q) state_q <= XMIT;
                    XMIT:    if ((snd_ptr_d == cmt_ptr_d) && !snd_mid_d) state_q <= IDLE;
                    DRAIN:   if (last_hs) state_q <= XMIT;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_hs) mem[wr_ptr_q[PW-2:0]] <= {bus.in_last, bus.in_data};
    end

`ifdef TLP_RETRY_LIMIT_EN
    logic [1:0] nack_cnt_q;
    logic       link_down_q;

    // ack in the same cycle as a nack restarts the run at one
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            nack_cnt_q  <= '0;
            link_down_q <= 1'b0;
        end else if (nack_eff) begin
            nack_cnt_q <= ack_eff ? 2'd1 : nack_cnt_q + 2'd1;
            if (!ack_eff && (nack_cnt_q == 2'd3)) link_down_q <= 1'b1;
        end else if (ack_eff) begin
            nack_cnt_q <= '0;
        end
    end
    assign link_down = link_down_q;
`else
    assign link_down = 1'b0;
`endif

endmodule

// File: doc/tlp_retry_buf.md
TLP_RETRY_BUF -- requirements
Module: tlp_retry_buf

Interface
REQ-001 SHALL take parameters: DEPTH_LOG2, default 6, log2 of the word-store depth (64 x 32-bit); MAX_TLP, default 8, maximum number of TLPs held.
REQ-002 SHALL use clock clk, rising-edge.
REQ-003 SHALL use reset rst_n, asynchronous, active-high.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  reset
- in_data  in  32  TLP word from the packer
- in_valid  in  1  in_data valid
- in_last  in  1  final word of the TLP
- in_ready  out  1  word accepted when in_valid & in_ready
- out_data  out  32  word to the link (rx_tlp_data)
- out_valid  out  1  out_data valid
- out_last  out  1  final word of the TLP
- out_ready  in  1  link accepts the word
- ack  in  1  1-cycle pulse; oldest sent TLP received good
- nack  in  1  1-cycle pulse; oldest sent TLP received bad
- outstanding  out  4  count of TLPs held (committed + in-progress)
- replay  out  1  1-cycle pulse when the send pointer rewinds
- proto_err  out  1  sticky; ack/nack with no sent-unacked TLP
- link_down  out  1  sticky retry-limit failure

Function
REQ-005 SHALL store words in a circular RAM using pointers wr_ptr, snd_ptr and ack_ptr (DEPTH_LOG2+1 bits each, wrap bit for full/empty), plus a MAX_TLP-entry length FIFO of TLP word counts.
REQ-006 SHALL drive in_ready=1 iff: free words >= 1; and (mid-TLP or TLP count < MAX_TLP); and link_down=0.
REQ-007 SHALL forward store-and-forward: a TLP becomes sendable on the cycle after its in_last word is accepted; no word of an uncommitted TLP SHALL appear on out_data.
REQ-008 SHALL drive out_valid=1 iff snd_ptr != committed write pointer and link_down=0. out_data/out_last come from RAM[snd_ptr]. snd_ptr advances on out_valid & out_ready.
REQ-009 SHALL hold out_data/out_last stable while out_valid=1 and out_ready=0.
REQ-010 SHALL use states IDLE (nothing sendable), XMIT (sending), DRAIN (nack seen mid-TLP). Transitions:
- IDLE->XMIT when a TLP is sendable.
- XMIT->IDLE when snd_ptr reaches the committed pointer at a TLP boundary.
- XMIT->DRAIN on nack mid-TLP.
- DRAIN->XMIT after the out_last handshake, then rewind.
REQ-011 ack SHALL pop the length FIFO, advance ack_ptr by that length, free those words next cycle and decrement outstanding.
REQ-012 nack at a TLP boundary SHALL set snd_ptr=ack_ptr next cycle and pulse replay; nack mid-TLP SHALL rewind only after the current out_last handshake.
REQ-013 A replay SHALL resend every sent-unacked TLP in order, then continue with newer TLPs without a gap.
REQ-014 ack and nack in the same cycle SHALL process ack first, then nack against the new oldest TLP; a nack with no remaining sent-unacked TLP SHALL be ignored.
REQ-015 ack/nack with zero sent-unacked TLPs SHALL be ignored and set proto_err.
REQ-016 A simultaneous ack free and in write at full SHALL not accept the word that cycle (in_ready computed from the registered free count).
REQ-017 A TLP longer than 2^DEPTH_LOG2 words is a protocol violation; behaviour is undefined and not checked.

Reset
REQ-018 While rst_n=1, SHALL clear all pointers, the length FIFO and the state (IDLE); in_ready=0, out_valid=0, out_last=0, out_data=0, outstanding=0, replay=0, proto_err=0, link_down=0.
REQ-019 Reset mid-TLP or mid-replay SHALL discard all stored content; the first post-reset accept starts a new TLP.

Configuration
REQ-020 Macro TLP_RETRY_LIMIT_EN defined: a 2-bit consecutive-nack counter, cleared by ack; the 4th consecutive nack sets link_down, forcing in_ready=0 and out_valid=0 until reset.
REQ-021 Macro TLP_RETRY_LIMIT_EN undefined: link_down is tied 0 and replays are unlimited.

Verification
REQ-022 Write a 4-word TLP (0x01234567 x4), out_ready=1 -> out_valid rises the cycle after in_last; 4 words emitted; out_last on word 4; outstanding=1 until ack, then 0.
REQ-023 Send 3 TLPs, nack after the 2nd fully sent -> replay pulse, TLP1 and TLP2 resent in order, then TLP3; ack x3 -> outstanding=0.
REQ-024 nack while word 2 of 4 of a TLP is on the link -> word 4 completes with out_last, then rewind to ack_ptr.
REQ-025 Fill to MAX_TLP=8 committed TLPs with no ack -> in_ready=0; one ack -> in_ready=1 next cycle.
REQ-026 ack with nothing sent -> proto_err=1, sticky, pointers unchanged; rst_n pulse mid-TLP -> all outputs at reset values.
REQ-027 With TLP_RETRY_LIMIT_EN defined, 4 consecutive nacks -> link_down=1, out_valid=0, in_ready=0; undefined -> replays continue.
